// File: rtl/float_div_seq_pkg.sv
// Shared single-precision widths, divider FSM states and a small packing helper
// for the sequential restoring floating-point divider.
package float_div_seq_pkg;

    localparam int float_width      = 32;
    localparam int float_exp_width  = 8;
    localparam int float_mant_width = 23;

    // Significand with hidden bit, and the quotient/remainder width (one guard bit).
    localparam int sig_width = float_mant_width + 1;
    localparam int quo_width = float_mant_width + 2;

    // Number of restoring steps per division, expressed as the last counter value.
    localparam logic [4:0] last_step = 5'(quo_width - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } e_div_state;

    function automatic logic [float_width-1:0] pack_float(
        input logic                        sign,
        input logic [float_exp_width-1:0]  exp,
        input logic [float_mant_width-1:0] mant
    );
        return {sign, exp, mant};
    endfunction

endpackage

// File: rtl/float_div_seq_step.sv
// One restoring-division step: compare the partial remainder with the divisor,
// emit one quotient bit and the shifted next remainder.
module float_div_step
    import float_div_seq_pkg::*;
(
    input  logic [quo_width-1:0] rem,
    input  logic [sig_width-1:0] mb,
    output logic                 qbit,
    output logic [quo_width-1:0] rem_next
);

    logic [quo_width-1:0] mb_ext;
    logic [quo_width-1:0] diff;
    logic [quo_width-1:0] sel;

    assign mb_ext   = {1'b0, mb};
    assign qbit     = (rem >= mb_ext);
    assign diff     = rem - mb_ext;
    assign sel      = qbit ? diff : rem;
    // The remainder stays below 2*mb, so the shifted value always fits.
    assign rem_next = sel << 1;

endmodule

// File: rtl/float_div_seq.sv
// Sequential IEEE-754 single-precision divider: one quotient bit per clock,
// truncating normalisation, one-cycle ack pulse with a divide-by-zero flag.
module float_div_seq
    import float_div_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [float_width-1:0] a,
    input  logic [float_width-1:0] b,
    output logic                   ack,
    output logic [float_width-1:0] out,
    output logic                   busy,
    output logic                   dz
);

    e_div_state state_reg, state_next;

    logic                        sign_reg, sign_next;
    logic [float_exp_width-1:0]  ea_reg, ea_next;
    logic [float_exp_width-1:0]  eb_reg, eb_next;
    logic [sig_width-1:0]        mb_reg, mb_next;
    logic [quo_width-1:0]        rem_reg, rem_next;
    logic [quo_width-1:0]        q_reg, q_next;
    logic [4:0]                  cnt_reg, cnt_next;

    // Zero-operand results are held one cycle so they register ack one edge
    // after acceptance, while the FSM itself never leaves IDLE.
    logic                        sp_valid_reg, sp_valid_next;
    logic [float_width-1:0]      sp_out_reg, sp_out_next;
    logic                        sp_dz_reg, sp_dz_next;

    logic                        ack_reg, ack_next;
    logic [float_width-1:0]      out_reg, out_next;
    logic                        busy_reg, busy_next;
    logic                        dz_reg, dz_next;

    logic                        step_qbit;
    logic [quo_width-1:0]        step_rem;
    logic signed [9:0]           e_sum;
    logic [float_mant_width-1:0] mant;
    logic                        sign_in;

    float_div_step u_step (
        .rem      (rem_reg),
        .mb       (mb_reg),
        .qbit     (step_qbit),
        .rem_next (step_rem)
    );

    assign sign_in = a[float_width-1] ^ b[float_width-1];

    // q[24] set means the quotient lies in [1,2): bump the exponent, drop one bit.
    assign e_sum = {2'b00, ea_reg} - {2'b00, eb_reg} + 10'd126 + {9'd0, q_reg[quo_width-1]};
    assign mant  = q_reg[quo_width-1] ? q_reg[quo_width-2:1] : q_reg[float_mant_width-1:0];

    always_comb begin
        state_next    = state_reg;
        sign_next     = sign_reg;
        ea_next       = ea_reg;
        eb_next       = eb_reg;
        mb_next       = mb_reg;
        rem_next      = rem_reg;
        q_next        = q_reg;
        cnt_next      = cnt_reg;
        sp_valid_next = 1'b0;
        sp_out_next   = '0;
        sp_dz_next    = 1'b0;
        ack_next      = 1'b0;
        out_next      = '0;
        dz_next       = 1'b0;

        if (sp_valid_reg) begin
            ack_next = 1'b1;
            out_next = sp_out_reg;
            dz_next  = sp_dz_reg;
        end

        case (state_reg)
            IDLE: begin
                if (req) begin
                    sign_next = sign_in;
                    ea_next   = a[30:23];
                    eb_next   = b[30:23];
                    mb_next   = {1'b1, b[float_mant_width-1:0]};
                    if (a[30:23] == '0) begin
                        sp_valid_next = 1'b1;
                        sp_out_next   = '0;
                    end else if (b[30:23] == '0) begin
                        sp_valid_next = 1'b1;
                        sp_out_next   = pack_float(sign_in, 8'hFF, '0);
                        sp_dz_next    = 1'b1;
                    end else begin
                        rem_next   = {2'b01, a[float_mant_width-1:0]};
                        q_next     = '0;
                        cnt_next   = '0;
                        state_next = DIV;
                    end
                end
            end
            DIV: begin
                rem_next = step_rem;
                q_next   = {q_reg[quo_width-2:0], step_qbit};
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == last_step) begin
                    state_next = NORM;
                end
            end
            NORM: begin
                ack_next = 1'b1;
                if (e_sum >= 10'sd255) begin
                    out_next = pack_float(sign_reg, 8'hFF, '0);
                end else if (e_sum <= 10'sd0) begin
                    out_next = '0;
                end else begin
                    out_next = pack_float(sign_reg, e_sum[7:0], mant);
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            sign_reg     <= 1'b0;
            ea_reg       <= '0;
            eb_reg       <= '0;
            mb_reg       <= '0;
            rem_reg      <= '0;
            q_reg        <= '0;
            cnt_reg      <= '0;
            sp_valid_reg <= 1'b0;
            sp_out_reg   <= '0;
            sp_dz_reg    <= 1'b0;
            ack_reg      <= 1'b0;
            out_reg      <= '0;
            busy_reg     <= 1'b0;
            dz_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sign_reg     <= sign_next;
            ea_reg       <= ea_next;
            eb_reg       <= eb_next;
            mb_reg       <= mb_next;
            rem_reg      <= rem_next;
            q_reg        <= q_next;
            cnt_reg      <= cnt_next;
            sp_valid_reg <= sp_valid_next;
            sp_out_reg   <= sp_out_next;
            sp_dz_reg    <= sp_dz_next;
            ack_reg      <= ack_next;
            out_reg      <= out_next;
            busy_reg     <= busy_next;
            dz_reg       <= dz_next;
        end
    end

    assign ack  = ack_reg;
    assign out  = out_reg;
    assign busy = busy_reg;
    assign dz   = dz_reg;

endmodule

// File: tb/tb_float_div_seq.sv
// Randomised and directed checks of float_div_seq against an arithmetic
// reference model (integer long division on the significands).
module tb_float_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        ack;
    logic [31:0] dut_out;
    logic        busy;
    logic        dz;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    float_div_seq dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .a    (a_in),
        .b    (b_in),
        .ack  (ack),
        .out  (dut_out),
        .busy (busy),
        .dz   (dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // Reference: quotient of the real values, truncated to 23 fraction bits.
    function automatic void model(input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] r, output logic d, output int lat);
        int          ea;
        int          eb;
        int          e;
        logic        s;
        logic [63:0] ma;
        logic [63:0] mb;
        logic [63:0] q;
        logic [22:0] m;
        ea  = int'(av[30:23]);
        eb  = int'(bv[30:23]);
        s   = av[31] ^ bv[31];
        r   = 32'h0;
        d   = 1'b0;
        lat = 1;
        if (ea == 0) begin
            r = 32'h0;
        end else if (eb == 0) begin
            r = {s, 8'hFF, 23'h0};
            d = 1'b1;
        end else begin
            lat = 26;
            ma  = {40'd0, 1'b1, av[22:0]};
            mb  = {40'd0, 1'b1, bv[22:0]};
            q   = (ma << 24) / mb;
            if (q >= 64'd16777216) begin
                e = ea - eb + 127;
                m = q[23:1];
            end else begin
                e = ea - eb + 126;
                m = q[22:0];
            end
            if (e >= 255)     r = {s, 8'hFF, 23'h0};
            else if (e <= 0)  r = 32'h0;
            else              r = {s, 8'(e), m};
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [7:0] e;
        int         sel;
        sel = int'($urandom_range(0, 11));
        if (sel == 0)      e = 8'h00;
        else if (sel == 1) e = 8'hFF;
        else               e = 8'($urandom_range(1, 254));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    function automatic logic [31:0] rand_normal();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    // Issues one request and measures the response; comparisons are left to the caller.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input bit scramble,
                         output int lat, output logic [31:0] res, output logic resdz,
                         output int busy_hi, output int leak, output logic ack_twice);
        a_in = av;
        b_in = bv;
        req  = 1'b1;
        @(posedge clk); #1;
        req       = 1'b0;
        lat       = 0;
        busy_hi   = 0;
        leak      = 0;
        ack_twice = 1'b0;
        while (!ack && lat < 40) begin
            if (busy) busy_hi++;
            if (dut_out !== 32'h0 || dz !== 1'b0) leak++;
            if (scramble) begin
                a_in = $urandom;
                b_in = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (busy) busy_hi++;
        res   = dut_out;
        resdz = dz;
        if (ack) begin
            @(posedge clk); #1;
            ack_twice = ack;
        end
        $display("op a=%h b=%h out=%h dz=%0d lat=%0d", av, bv, res, resdz, lat);
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        req  = 1'b0;
        a_in = 32'h0;
        b_in = 32'h0;
        #1;
        total++;
        if ({ack, busy, dz, dut_out} !== 35'h0) begin
            bad++;
            $display("FAIL reset_async: got ack=%b busy=%b dz=%b out=%h want all 0", ack, busy, dz, dut_out);
        end
        a_in = 32'h40C00000;
        b_in = 32'h40000000;
        req  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ack, busy, dz, dut_out} !== 35'h0) begin
            bad++;
            $display("FAIL reset_held: got ack=%b busy=%b dz=%b out=%h want all 0", ack, busy, dz, dut_out);
        end
        req = 1'b0;
        rst = 1'b1;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        d;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t        tbl[9];
        int          lat;
        int          busy_hi;
        int          leak;
        logic [31:0] res;
        logic        resdz;
        logic        again;
        tbl[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26};
        tbl[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26};
        tbl[2] = '{32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, 26};
        tbl[3] = '{32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1};
        tbl[4] = '{32'hC0000000, 32'h00000000, 32'hFF800000, 1'b1, 1};
        tbl[5] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 26};
        tbl[6] = '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 26};
        tbl[7] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1};
        tbl[8] = '{32'h80000000, 32'hC0000000, 32'h00000000, 1'b0, 1};
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].a, tbl[i].b, 1'b0, lat, res, resdz, busy_hi, leak, again);
            total++;
            if (res !== tbl[i].r) begin
                bad++;
                $display("FAIL dir_out[%0d]: got %h want %h", i, res, tbl[i].r);
            end
            total++;
            if (resdz !== tbl[i].d) begin
                bad++;
                $display("FAIL dir_dz[%0d]: got %b want %b", i, resdz, tbl[i].d);
            end
            total++;
            if (lat != tbl[i].lat) begin
                bad++;
                $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, tbl[i].lat);
            end
            total++;
            if (busy_hi != ((tbl[i].lat == 26) ? 26 : 0)) begin
                bad++;
                $display("FAIL dir_busy[%0d]: got %0d busy cycles want %0d", i, busy_hi, (tbl[i].lat == 26) ? 26 : 0);
            end
            total++;
            if (leak != 0 || again !== 1'b0) begin
                bad++;
                $display("FAIL dir_pulse[%0d]: got leak=%0d ack_again=%b want 0 0", i, leak, again);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] exp_r;
        logic        exp_d;
        int          exp_lat;
        int          lat;
        int          busy_hi;
        int          leak;
        logic [31:0] res;
        logic        resdz;
        logic        again;
        for (int i = 0; i < 40; i++) begin
            av = rand_operand();
            bv = rand_operand();
            model(av, bv, exp_r, exp_d, exp_lat);
            do_op(av, bv, (i % 2) == 1, lat, res, resdz, busy_hi, leak, again);
            total++;
            if (res !== exp_r || resdz !== exp_d) begin
                bad++;
                $display("FAIL rnd_result[%0d]: got out=%h dz=%b want out=%h dz=%b", i, res, resdz, exp_r, exp_d);
            end
            total++;
            if (lat != exp_lat || leak != 0 || again !== 1'b0) begin
                bad++;
                $display("FAIL rnd_timing[%0d]: got lat=%0d leak=%0d ack_again=%b want lat=%0d 0 0",
                         i, lat, leak, again, exp_lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1;
        logic [31:0] b1;
        logic [31:0] a2;
        logic [31:0] b2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        d;
        int          l;
        int          t0;
        int          t1;
        int          t2;
        int          k;
        int          extra;
        a1 = rand_normal();
        b1 = rand_normal();
        a2 = rand_normal();
        b2 = rand_normal();
        model(a1, b1, e1, d, l);
        model(a2, b2, e2, d, l);
        a_in = a1;
        b_in = b1;
        req  = 1'b1;
        @(posedge clk); #1;
        t0   = cyc;
        a_in = a2;
        b_in = b2;
        k    = 0;
        while (!ack && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        t1 = cyc;
        r1 = dut_out;
        @(posedge clk); #1;
        req = 1'b0;
        k   = 0;
        while (!ack && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        t2 = cyc;
        r2 = dut_out;
        $display("b2b first=%h at %0d second=%h at %0d", r1, t1 - t0, r2, t2 - t0);
        total++;
        if (t1 - t0 != 26) begin
            bad++;
            $display("FAIL b2b_first_latency: got %0d want 26", t1 - t0);
        end
        total++;
        if (t2 - t1 != 27) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d want 27", t2 - t1);
        end
        total++;
        if (r1 !== e1) begin
            bad++;
            $display("FAIL b2b_first_out: got %h want %h", r1, e1);
        end
        total++;
        if (r2 !== e2) begin
            bad++;
            $display("FAIL b2b_second_out: got %h want %h", r2, e2);
        end
        extra = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            if (ack) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL b2b_no_queue: got %0d extra acks want 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] exp_r;
        logic        exp_d;
        int          exp_lat;
        int          lat;
        int          busy_hi;
        int          leak;
        logic [31:0] res;
        logic        resdz;
        logic        again;
        int          stray;
        a_in = rand_normal();
        b_in = rand_normal();
        req  = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({ack, busy, dz, dut_out} !== 35'h0) begin
            bad++;
            $display("FAIL abort_outputs: got ack=%b busy=%b dz=%b out=%h want all 0", ack, busy, dz, dut_out);
        end
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b1;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (ack || busy) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL abort_no_ack: got %0d ack/busy cycles want 0", stray);
        end
        av = rand_normal();
        bv = rand_normal();
        model(av, bv, exp_r, exp_d, exp_lat);
        do_op(av, bv, 1'b1, lat, res, resdz, busy_hi, leak, again);
        total++;
        if (res !== exp_r || resdz !== exp_d || lat != exp_lat) begin
            bad++;
            $display("FAIL abort_recover: got out=%h dz=%b lat=%0d want out=%h dz=%b lat=%0d",
                     res, resdz, lat, exp_r, exp_d, exp_lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
